mu0_cpu_delay0: RTL and testbench
=================================

Name: mu0_cpu_delay0

Overview:
- Multi-cycle MU0 processor core that sits directly upstream of the zero-delay instruction/data memory models.
- Drives the single shared address/read/write bus and consumes combinational readdata in the same cycle.
- Executes the 8-instruction MU0 ISA and exposes ACC and run status for testbenches.
- Target memory: any delay-0 RAM; readdata is valid in the same cycle that address and read are presented.

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- address  output  12  memory word address
- read  output  1  read strobe; readdata sampled at the next rising edge
- write  output  1  write strobe; memory captures writedata at the next rising edge
- writedata  output  16  store data (always ACC)
- readdata  input  16  memory read data, combinational from address
- running  output  1  high until STP (or trap) executes
- fault  output  1  illegal-opcode trap flag
- acc  output  16  current accumulator (debug)

Behaviour:
- Instruction format: opcode = IR[15:12], S = IR[11:0].
- Opcodes:
  - 0 LDA: ACC = mem[S]
  - 1 STO: mem[S] = ACC
  - 2 ADD: ACC = ACC + mem[S]
  - 3 SUB: ACC = ACC - mem[S]
  - 4 JMP: PC = S
  - 5 JGE: if ACC[15] == 0, PC = S
  - 6 JNE: if ACC != 0, PC = S
  - 7 STP: halt
- Arithmetic: 16-bit modulo, carry/overflow discarded. PC is 12-bit and wraps 4095 -> 0.
- Registers: PC, IR, ACC, state. All outputs decode from registers only (Moore); no path from readdata to any output.
- Reset (async, rst_n low): PC = RESET_PC, IR = 0, ACC = 0, state = FETCH, fault = 0.
- Output values while in reset: running = 1, read = 1, write = 0, address = RESET_PC, writedata = 0.
- FETCH state:
  - Drive address = PC, read = 1, write = 0.
  - At the edge: IR <= readdata, PC <= PC + 1, go to EXEC.
- EXEC state (address = S in all cases):
  - LDA / ADD / SUB: read = 1; ACC updated from readdata at the edge; go to FETCH.
  - STO: write = 1, read = 0, writedata = ACC; go to FETCH.
  - JMP / JGE / JNE: read = 0, write = 0; PC <= S if taken; go to FETCH.
  - STP: read = 0, write = 0; go to HALTED.
- HALTED state:
  - address = PC, read = 0, write = 0, running = 0.
  - Stays in HALTED until reset.
- Every instruction takes 2 cycles (CPI = 2).
- read and write are never both high in any cycle.
- writedata equals ACC in every state; it is only meaningful while write = 1.
- Reset asserted mid-instruction abandons the instruction: no partial ACC/PC update, and any pending write is not issued after reset deasserts.

Optional Feature:
- Macro: MU0_ILLEGAL_OPCODE_TRAP_EN.
- Defined: opcodes 8-F in EXEC go to HALTED with fault = 1 and running = 0. fault stays high until reset.
- Undefined: opcodes 8-F execute as a 2-cycle NOP (no bus access, PC already incremented); fault is tied to 0.
- The port list is identical in both builds.

Test Plan:
- Reset only: hold rst_n low, toggle clk -> address = 000, read = 1, write = 0, running = 1, acc = 0000.
- Countdown program {0004, 2005, 6001, 7000, 000A, FFFF} on delay-0 memory -> running falls after exactly 44 rising edges from rst_n release; acc = 0000; address = 004; write never asserted; address never > 5.
- Store/load: {1006, 0006, 7000} with mem[6] preset to 1234 and ACC = 0 after reset:
  - cycle 2: write = 1, address = 006, writedata = 0000;
  - next LDA reads 0000 -> acc = 0000.
- Branch conditions:
  - ACC = 8000: JGE is not taken.
  - ACC = 7FFF: JGE is taken.
  - ACC = 0000: JNE falls through, PC = next word.
- Illegal opcode: word 0 = 8000 -> with the macro, fault = 1 and running = 0 after 2 edges; without it, PC advances to 001 and the following instruction executes.
- Reset mid-STO: drop rst_n during the STO EXEC cycle -> write = 0 immediately; after release, fetch restarts at address 000.

Source files
------------

// File: rtl/mu0_cpu_delay0.sv
// Multi-cycle MU0 core for zero-delay memory: FETCH/EXEC per instruction, Moore bus outputs.
// Optional MU0_ILLEGAL_OPCODE_TRAP_EN: opcodes 8-F halt with fault; otherwise they act as NOPs.
module mu0_cpu_delay0 #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] address,
    output logic        read,
    output logic        write,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    output logic        running,
    output logic        fault,
    output logic [15:0] acc
);

    typedef enum logic [1:0] {StFetch, StExec, StHalted} state_e;

    localparam logic [3:0] OpLda = 4'h0;
    localparam logic [3:0] OpSto = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpJmp = 4'h4;
    localparam logic [3:0] OpJge = 4'h5;
    localparam logic [3:0] OpJne = 4'h6;
    localparam logic [3:0] OpStp = 4'h7;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] acc_q, acc_d;
    logic        fault_q, fault_d;

    logic [3:0]  opcode;
    logic [11:0] operand;

    assign opcode  = ir_q[15:12];
    assign operand = ir_q[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            acc_q   <= 16'h0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            fault_q <= fault_d;
        end
    end

    // Bus strobes and address decode from state/IR only, so readdata never reaches an output.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        fault_d = fault_q;
        address = pc_q;
        read    = 1'b0;
        write   = 1'b0;

        case (state_q)
            StFetch: begin
                read    = 1'b1;
                ir_d    = readdata;
                pc_d    = pc_q + 12'd1;
                state_d = StExec;
            end
            StExec: begin
                address = operand;
                state_d = StFetch;
                case (opcode)
                    OpLda: begin
                        read  = 1'b1;
                        acc_d = readdata;
                    end
                    OpSto: write = 1'b1;
                    OpAdd: begin
                        read  = 1'b1;
                        acc_d = acc_q + readdata;
                    end
                    OpSub: begin
                        read  = 1'b1;
                        acc_d = acc_q - readdata;
                    end
                    OpJmp: pc_d = operand;
                    OpJge: if (!acc_q[15]) pc_d = operand;
                    OpJne: if (acc_q != 16'h0000) pc_d = operand;
                    OpStp: state_d = StHalted;
                    default: begin
`ifdef MU0_ILLEGAL_OPCODE_TRAP_EN
                        state_d = StHalted;
                        fault_d = 1'b1;
`else
                        state_d = StFetch;
`endif
                    end
                endcase
            end
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    assign writedata = acc_q;
    assign acc       = acc_q;
    assign running   = (state_q != StHalted);
    assign fault     = fault_q;

endmodule

// File: tb/tb_mu0_cpu_delay0.sv
// Self-checking bench for mu0_cpu_delay0: directed scenarios plus random programs
// compared against an instruction-level MU0 interpreter.
module tb_mu0_cpu_delay0;

    logic        clk;
    logic        rst_n;
    logic [11:0] address;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        running;
    logic        fault;
    logic [15:0] acc;

    logic [15:0] mem [0:4095];
    logic [15:0] img [0:4095];
    logic [15:0] mdl [0:4095];

    int n_tests;
    int n_fail;

    mu0_cpu_delay0 #(.RESET_PC(12'h000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .running   (running),
        .fault     (fault),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-delay memory; image reloads on every edge while reset is held.
    assign readdata = mem[address];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem[i] <= img[i];
        end else if (write) begin
            mem[address] <= writedata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output int edges, output bit saw_write,
                                  output bit saw_both, output logic [11:0] max_addr);
        edges     = 0;
        saw_write = 1'b0;
        saw_both  = 1'b0;
        max_addr  = 12'h000;
        while (edges < budget) begin
            if (write) saw_write = 1'b1;
            if (read && write) saw_both = 1'b1;
            if (address > max_addr) max_addr = address;
            if (!running) break;
            tick();
            edges++;
        end
    endtask

    // Instruction-level interpreter over mdl[].
    task automatic model_run(input int steps, output logic [11:0] pc, output logic [15:0] a,
                             output bit halted, output bit flt);
        logic [15:0] ir;
        logic [11:0] s;
        pc = 12'h000; a = 16'h0000; halted = 1'b0; flt = 1'b0;
        for (int n = 0; n < steps && !halted; n++) begin
            ir = mdl[pc];
            s  = ir[11:0];
            pc = pc + 12'd1;
            case (int'(ir[15:12]))
                0: a = mdl[s];
                1: mdl[s] = a;
                2: a = a + mdl[s];
                3: a = a - mdl[s];
                4: pc = s;
                5: if (a < 16'h8000) pc = s;
                6: if (a != 0) pc = s;
                7: halted = 1'b1;
                default: begin
`ifdef MU0_ILLEGAL_OPCODE_TRAP_EN
                    halted = 1'b1;
                    flt = 1'b1;
`endif
                end
            endcase
        end
    endtask

    task automatic test_reset();
        clear_img();
        rst_n = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if (address !== 12'h000 || read !== 1'b1 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h read=%b write=%b, want 000 1 0", address, read, write);
        end
        n_tests++;
        if (running !== 1'b1 || acc !== 16'h0000 || writedata !== 16'h0000 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: running=%b acc=%h wd=%h fault=%b, want 1 0000 0000 0",
                     running, acc, writedata, fault);
        end
    endtask

    task automatic test_countdown();
        int edges;
        bit sw, sb;
        logic [11:0] ma;
        clear_img();
        img[0] = 16'h0004; img[1] = 16'h2005; img[2] = 16'h6001;
        img[3] = 16'h7000; img[4] = 16'h000A; img[5] = 16'hFFFF;
        reset_dut();
        run_until_halt(200, edges, sw, sb, ma);
        n_tests++;
        if (edges !== 44 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL countdown_edges: edges=%0d running=%b, want 44 0", edges, running);
        end
        n_tests++;
        if (acc !== 16'h0000 || address !== 12'h004) begin
            n_fail++;
            $display("FAIL countdown_final: acc=%h addr=%h, want 0000 004", acc, address);
        end
        n_tests++;
        if (sw || sb || ma > 12'h005) begin
            n_fail++;
            $display("FAIL countdown_bus: saw_write=%b saw_both=%b max_addr=%h, want 0 0 <=005",
                     sw, sb, ma);
        end
    endtask

    task automatic test_store_load();
        int edges;
        bit sw, sb;
        logic [11:0] ma;
        clear_img();
        img[0] = 16'h1006; img[1] = 16'h0006; img[2] = 16'h7000; img[6] = 16'h1234;
        reset_dut();
        tick();
        n_tests++;
        if (write !== 1'b1 || read !== 1'b0 || address !== 12'h006 || writedata !== 16'h0000) begin
            n_fail++;
            $display("FAIL sto_bus: write=%b read=%b addr=%h wd=%h, want 1 0 006 0000",
                     write, read, address, writedata);
        end
        run_until_halt(50, edges, sw, sb, ma);
        n_tests++;
        if (acc !== 16'h0000 || mem[6] !== 16'h0000 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL sto_lda: acc=%h mem6=%h running=%b, want 0000 0000 0",
                     acc, mem[6], running);
        end
    endtask

    task automatic test_branches();
        logic [15:0] vals [3] = '{16'h8000, 16'h7FFF, 16'h0000};
        logic [15:0] ops  [3] = '{16'h5005, 16'h5005, 16'h6005};
        logic [11:0] want [3] = '{12'h003, 12'h006, 12'h003};
        int edges;
        bit sw, sb;
        logic [11:0] ma;
        for (int t = 0; t < 3; t++) begin
            clear_img();
            img[0] = 16'h000A; img[1] = ops[t]; img[2] = 16'h7000;
            img[5] = 16'h7000; img[10] = vals[t];
            reset_dut();
            run_until_halt(50, edges, sw, sb, ma);
            n_tests++;
            if (address !== want[t] || edges !== 6 || acc !== vals[t]) begin
                n_fail++;
                $display("FAIL branch_%0d: addr=%h edges=%0d acc=%h, want %h 6 %h",
                         t, address, edges, acc, want[t], vals[t]);
            end
        end
    endtask

    task automatic test_illegal();
        clear_img();
        img[0] = 16'h8000; img[1] = 16'h7000;
        reset_dut();
        tick();
        tick();
`ifdef MU0_ILLEGAL_OPCODE_TRAP_EN
        n_tests++;
        if (fault !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_trap: fault=%b running=%b, want 1 0", fault, running);
        end
`else
        n_tests++;
        if (fault !== 1'b0 || running !== 1'b1 || address !== 12'h001) begin
            n_fail++;
            $display("FAIL illegal_nop: fault=%b running=%b addr=%h, want 0 1 001",
                     fault, running, address);
        end
        tick();
        tick();
        n_tests++;
        if (running !== 1'b0 || address !== 12'h002) begin
            n_fail++;
            $display("FAIL illegal_next: running=%b addr=%h, want 0 002", running, address);
        end
`endif
    endtask

    task automatic test_reset_mid_sto();
        clear_img();
        img[0] = 16'h0007; img[1] = 16'h1006; img[2] = 16'h7000;
        img[6] = 16'h5555; img[7] = 16'hABCD;
        reset_dut();
        tick();
        tick();
        tick();
        n_tests++;
        if (write !== 1'b1 || writedata !== 16'hABCD) begin
            n_fail++;
            $display("FAIL midsto_pre: write=%b wd=%h, want 1 abcd", write, writedata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (write !== 1'b0 || read !== 1'b1 || address !== 12'h000 || acc !== 16'h0000) begin
            n_fail++;
            $display("FAIL midsto_rst: write=%b read=%b addr=%h acc=%h, want 0 1 000 0000",
                     write, read, address, acc);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (write !== 1'b0 || read !== 1'b1 || address !== 12'h000) begin
            n_fail++;
            $display("FAIL midsto_release: write=%b read=%b addr=%h, want 0 1 000",
                     write, read, address);
        end
        tick();
        n_tests++;
        if (write !== 1'b0 || address !== 12'h007 || mem[6] !== 16'h5555) begin
            n_fail++;
            $display("FAIL midsto_refetch: write=%b addr=%h mem6=%h, want 0 007 5555",
                     write, address, mem[6]);
        end
    endtask

    task automatic test_random();
        logic [11:0] pc;
        logic [15:0] a;
        bit halted, flt, both;
        int k, bad;
        logic [15:0] w;
        for (int t = 0; t < 24; t++) begin
            clear_img();
            for (int i = 0; i < 32; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 15) != 0) w[15] = 1'b0;
                w[11:5] = 7'h00;
                img[i] = w;
            end
            for (int i = 0; i < 4096; i++) mdl[i] = img[i];
            k = int'($urandom_range(1, 40));
            model_run(k, pc, a, halted, flt);
            reset_dut();
            both = 1'b0;
            for (int e = 0; e < 2 * k; e++) begin
                if (read && write) both = 1'b1;
                tick();
            end
            n_tests++;
            if (acc !== a || address !== pc || running !== !halted || fault !== flt || both) begin
                n_fail++;
                $display("FAIL random_%0d: acc=%h addr=%h run=%b fault=%b rw=%b, want %h %h %b %b 0",
                         t, acc, address, running, fault, both, a, pc, !halted, flt);
            end
            bad = 0;
            for (int i = 0; i < 32; i++) if (mem[i] !== mdl[i]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random_mem_%0d: %0d words differ, want 0", t, bad);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        test_reset();
        test_countdown();
        test_store_load();
        test_branches();
        test_illegal();
        test_reset_mid_sto();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
